calc_cmd_sequencer: RTL and testbench
=====================================

Name: calc_cmd_sequencer

Overview:
Command scheduler in front of the calculator core. It buffers key codes from the keypad front-end in a small FIFO. It issues them to the core's cmd input one at a time, each as a single-cycle pulse. Between pulses it drives a neutral idle code and waits on the core's status handshake before issuing the next command. This stops held or repeated cmd values being consumed as multiple digits, and it serialises the core's printing and multiplication-busy periods.

Parameters:
DEPTH, 8, FIFO entries; power of two, ≥2.
ACK_TIMEOUT, 4, cycles to wait for status to leave READY before treating a command as silently absorbed (e.g. operator in OP state).
CNT_W, 8, width of issued_count.

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
key_valid  in  1  key_code valid this cycle
key_code  in  4  cmd code: 0-9 digit, A/B/C op, E '=', F backspace
key_ready  out  1  FIFO can accept; a push occurs when key_valid && key_ready
calc_status  in  2  core status: 00 ERR, 01 BUSY, 10 READY, 11 PRINTING
calc_cmd  out  4  registered command to core; IDLE_CMD (4'hD) when not issuing
fifo_level  out  $clog2(DEPTH)+1  current occupancy
busy  out  1  state != S_IDLE or FIFO non-empty
error  out  1  core reported ERR; sticky until reset
overflow  out  1  sticky: key_valid seen while key_ready=0 (outside S_ERROR)
issued_count  out  CNT_W  commands issued; wraps modulo 2^CNT_W

Behaviour:
- Reset is asynchronous. Reset values: calc_cmd=IDLE_CMD, state=S_IDLE, FIFO empty, fifo_level=0, key_ready=1, busy=0, error=0, overflow=0, issued_count=0, timeout counter=0. Reset mid-operation discards FIFO contents and any in-flight command.
- key_ready = !full && state!=S_ERROR. It is combinational from registered state.
  - When full, a same-cycle pop does not allow a push.
  - A push and a pop in the same cycle on a non-full, non-empty FIFO both take effect; the level is unchanged.
- S_IDLE:
  - If FIFO non-empty and calc_status==READY: calc_cmd<=head, pop, issued_count+1, timer<=0, go to S_WAIT_ACK.
  - Otherwise calc_cmd<=IDLE_CMD.
- Latency: a key accepted at edge E0 into an empty FIFO, with the core READY, appears on calc_cmd from E1 to E2. It is exactly one cycle wide.
- S_WAIT_ACK: calc_cmd<=IDLE_CMD. The timer increments each cycle.
  - status != READY → S_WAIT_DONE.
  - Timer reaches ACK_TIMEOUT-1 with status still READY → S_IDLE.
- S_WAIT_DONE: calc_cmd=IDLE_CMD. Holds through BUSY(01) and PRINTING(11). status==READY → S_IDLE.
- Minimum spacing between two issued commands is 2 cycles of IDLE_CMD (WAIT_ACK + IDLE).
- ERR(00) on calc_status in any state, including the cycle an issue would happen:
  - Highest priority; no issue that cycle.
  - Go to S_ERROR, error<=1, FIFO flushed.
- S_ERROR: calc_cmd=IDLE_CMD, key_ready=0, pushes ignored, overflow is not set. The only exit is reset.
- issued_count wraps from 2^CNT_W-1 to 0 without flag.
- overflow sets in the cycle key_valid=1 && full. It never clears except by reset.

Decomposition:
- Package calc_pkg:
  - status enum: ST_ERR=2'b00, ST_BUSY=2'b01, ST_READY=2'b10, ST_PRINT=2'b11.
  - cmd constants: CMD_ADD=4'hA, CMD_SUB=4'hB, CMD_MUL=4'hC, CMD_IDLE=4'hD, CMD_EQ=4'hE, CMD_BS=4'hF.
  - Sequencer state enum: S_IDLE, S_WAIT_ACK, S_WAIT_DONE, S_ERROR.
- One sub-module, calc_cmd_fifo: synchronous FIFO with push, pop, flush, 4-bit data, full, empty and level outputs, parameter DEPTH.
  - Pointer wrap uses an extra MSB to distinguish full from empty.

Test Plan:
- Reset, then push key 3 with status held READY → calc_cmd=3 for exactly one cycle starting one edge after the accept; IDLE_CMD (4'hD) otherwise; issued_count=1.
- Push 1, 2, A back-to-back; model status going to 11 for 9 cycles after each digit; the A is absorbed with no status change → calc_cmd sequence 1, D…, 2, D…, A. Each digit waits for READY. A returns to S_IDLE after ACK_TIMEOUT=4 cycles.
- Hold status=BUSY (01) for 20 cycles after issuing C → no further issue until READY returns; fifo_level stays at its pending count.
- Push 9 keys with status held PRINTING → key_ready drops at level 8; 9th push rejected, overflow=1, fifo_level=8.
- Drive status=00 while the FIFO holds 3 entries → next edge error=1, fifo_level=0, key_ready=0, calc_cmd=D. Asserting reset clears error and restores key_ready=1.
- Issue 256 commands with CNT_W=8 → issued_count wraps to 0. Push and pop in the same cycle at level 4 → level stays 4.

Source files
------------

// File: rtl/calc_pkg.sv
// calc_pkg: shared encodings for the calculator command sequencer.
// Core status codes, keypad command codes and sequencer FSM states.
package calc_pkg;

   typedef enum logic [1:0] {
      ST_ERR   = 2'b00,
      ST_BUSY  = 2'b01,
      ST_READY = 2'b10,
      ST_PRINT = 2'b11
   } calc_status_t;

   localparam logic [3:0] CMD_ADD  = 4'hA;
   localparam logic [3:0] CMD_SUB  = 4'hB;
   localparam logic [3:0] CMD_MUL  = 4'hC;
   localparam logic [3:0] CMD_IDLE = 4'hD;
   localparam logic [3:0] CMD_EQ   = 4'hE;
   localparam logic [3:0] CMD_BS   = 4'hF;

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WAIT_ACK  = 2'd1,
      S_WAIT_DONE = 2'd2,
      S_ERROR     = 2'd3
   } seq_state_t;

endpackage

// File: rtl/calc_cmd_fifo.sv
// calc_cmd_fifo: synchronous key-code FIFO, DEPTH entries of 4 bits.
// Ports: clock, reset (async high), push/push_data, pop, flush,
// head (oldest entry), full, empty, level (occupancy).
module calc_cmd_fifo #(
   parameter int DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [3:0]               push_data,
   input  logic                     pop,
   input  logic                     flush,
   output logic [3:0]               head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   level
);

   localparam int AW = $clog2(DEPTH);

   // Pointers carry one extra MSB so full and empty differ.
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic [3:0]   mem [DEPTH];
   logic         do_push;
   logic         do_pop;

   assign do_push = push && !full;
   assign do_pop  = pop && !empty;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push)
            wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)
            rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clock) begin
      if (do_push && !flush)
         mem[wr_ptr[AW-1:0]] <= push_data;
   end

   assign head  = mem[rd_ptr[AW-1:0]];
   assign empty = (wr_ptr == rd_ptr);
   assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                  (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign level = wr_ptr - rd_ptr;

endmodule

// File: rtl/calc_cmd_sequencer.sv
// calc_cmd_sequencer: buffers keypad codes and issues them to the
// calculator core as one-cycle cmd pulses, paced by calc_status.
// Ports: clock, reset (async high); key_valid/key_code/key_ready
// keypad side; calc_status in, calc_cmd out (core side); status
// outputs fifo_level, busy, error, overflow, issued_count.
module calc_cmd_sequencer
   import calc_pkg::*;
#(
   parameter int DEPTH       = 8,
   parameter int ACK_TIMEOUT = 4,
   parameter int CNT_W       = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     key_valid,
   input  logic [3:0]               key_code,
   output logic                     key_ready,
   input  logic [1:0]               calc_status,
   output logic [3:0]               calc_cmd,
   output logic [$clog2(DEPTH):0]   fifo_level,
   output logic                     busy,
   output logic                     error,
   output logic                     overflow,
   output logic [CNT_W-1:0]         issued_count
);

   localparam int TW = $clog2(ACK_TIMEOUT) + 1;
   localparam logic [TW-1:0] T_LAST = TW'(ACK_TIMEOUT - 1);

   calc_status_t  status;
   seq_state_t    state;
   seq_state_t    state_nx;
   logic [TW-1:0] timer;
   logic [TW-1:0] timer_nx;
   logic [3:0]    cmd_nx;
   logic [3:0]    head;
   logic          fifo_full;
   logic          fifo_empty;
   logic          push;
   logic          pop;
   logic          flush;
   logic          err_in;
   logic          rdy;
   logic          issue;
   logic          ovf_set;

   assign status = calc_status_t'(calc_status);
   assign err_in = (status == ST_ERR);
   assign rdy    = (status == ST_READY);

   assign key_ready = !fifo_full && (state != S_ERROR);
   assign push      = key_valid && key_ready;
   assign busy      = (state != S_IDLE) || !fifo_empty;

   // ERR outranks an issue in the same cycle.
   assign issue = (state == S_IDLE) && !fifo_empty &&
                  rdy && !err_in;
   assign pop   = issue;
   assign flush = err_in && (state != S_ERROR);

   // Keys arriving in S_ERROR are dropped, not overflows.
   assign ovf_set = key_valid && fifo_full &&
                    (state != S_ERROR);

   calc_cmd_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (key_code),
      .pop       (pop),
      .flush     (flush),
      .head      (head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .level     (fifo_level)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state        <= S_IDLE;
         timer        <= '0;
         calc_cmd     <= CMD_IDLE;
         error        <= 1'b0;
         overflow     <= 1'b0;
         issued_count <= '0;
      end else begin
         state    <= state_nx;
         timer    <= timer_nx;
         calc_cmd <= cmd_nx;
         if (err_in)
            error <= 1'b1;
         if (ovf_set)
            overflow <= 1'b1;
         if (issue)
            issued_count <= issued_count + CNT_W'(1);
      end
   end

   always_comb begin
      state_nx = state;
      unique case (state)
         S_IDLE: begin
            if (err_in)
               state_nx = S_ERROR;
            else if (issue)
               state_nx = S_WAIT_ACK;
         end
         S_WAIT_ACK: begin
            // No reaction within the window means the core
            // absorbed the command silently.
            if (err_in)
               state_nx = S_ERROR;
            else if (!rdy)
               state_nx = S_WAIT_DONE;
            else if (timer == T_LAST)
               state_nx = S_IDLE;
         end
         S_WAIT_DONE: begin
            if (err_in)
               state_nx = S_ERROR;
            else if (rdy)
               state_nx = S_IDLE;
         end
         S_ERROR: begin
            state_nx = S_ERROR;
         end
      endcase
   end

   always_comb begin
      cmd_nx   = CMD_IDLE;
      timer_nx = timer;
      if (issue) begin
         cmd_nx   = head;
         timer_nx = '0;
      end else if (state == S_WAIT_ACK) begin
         timer_nx = timer + TW'(1);
      end
   end

endmodule

// File: tb/tb_calc_cmd_sequencer.sv
// tb_calc_cmd_sequencer: scenario tasks plus a randomized run
// against a queue-based model of the keypad-to-core command flow.
module tb_calc_cmd_sequencer;
   import calc_pkg::*;

   localparam int DEPTH = 8;
   localparam int ACK_TIMEOUT = 4;
   localparam int CNT_W = 8;
   localparam int LW = $clog2(DEPTH) + 1;

   logic             clock = 1'b0;
   logic             reset;
   logic             key_valid;
   logic [3:0]       key_code;
   logic             key_ready;
   logic [1:0]       calc_status;
   logic [3:0]       calc_cmd;
   logic [LW-1:0]    fifo_level;
   logic             busy;
   logic             error;
   logic             overflow;
   logic [CNT_W-1:0] issued_count;

   int total = 0;
   int bad = 0;

   calc_cmd_sequencer #(
      .DEPTH       (DEPTH),
      .ACK_TIMEOUT (ACK_TIMEOUT),
      .CNT_W       (CNT_W)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .key_valid    (key_valid),
      .key_code     (key_code),
      .key_ready    (key_ready),
      .calc_status  (calc_status),
      .calc_cmd     (calc_cmd),
      .fifo_level   (fifo_level),
      .busy         (busy),
      .error        (error),
      .overflow     (overflow),
      .issued_count (issued_count)
   );

   always #5 clock = ~clock;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      key_valid = 1'b0;
      key_code = 4'h0;
      calc_status = ST_READY;
      tick();
      tick();
      reset = 1'b0;
   endtask

   function automatic logic [3:0] rand_key();
      logic [3:0] k;
      k = 4'($urandom_range(0, 14));
      if (k == CMD_IDLE)
         k = CMD_BS;
      return k;
   endfunction

   task automatic test_reset();
      do_reset();
      total++;
      if (calc_cmd !== CMD_IDLE) begin
         bad++;
         $display("FAIL rst_cmd: got %h want %h", calc_cmd, CMD_IDLE);
      end
      total++;
      if (fifo_level !== LW'(0) || key_ready !== 1'b1) begin
         bad++;
         $display("FAIL rst_fifo: got lvl=%0d rdy=%b want 0 1",
                  fifo_level, key_ready);
      end
      total++;
      if ({busy, error, overflow} !== 3'b000) begin
         bad++;
         $display("FAIL rst_flags: got %b want 000",
                  {busy, error, overflow});
      end
      total++;
      if (issued_count !== CNT_W'(0)) begin
         bad++;
         $display("FAIL rst_cnt: got %0d want 0", issued_count);
      end
   endtask

   task automatic test_latency();
      do_reset();
      key_valid = 1'b1;
      key_code = 4'h3;
      tick();
      key_valid = 1'b0;
      total++;
      if (calc_cmd !== CMD_IDLE || fifo_level !== LW'(1)) begin
         bad++;
         $display("FAIL lat_e0: got cmd=%h lvl=%0d want d 1",
                  calc_cmd, fifo_level);
      end
      tick();
      total++;
      if (calc_cmd !== 4'h3 || issued_count !== CNT_W'(1)) begin
         bad++;
         $display("FAIL lat_e1: got cmd=%h cnt=%0d want 3 1",
                  calc_cmd, issued_count);
      end
      tick();
      total++;
      if (calc_cmd !== CMD_IDLE) begin
         bad++;
         $display("FAIL lat_e2: got %h want d", calc_cmd);
      end
      repeat (3) tick();
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL lat_idle: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_sequence();
      logic [3:0] keys [3];
      logic [1:0] st;
      int np = 0;
      int ni = 0;
      int left = 0;
      int cyc = 0;
      int last = -100;
      keys[0] = 4'h1;
      keys[1] = 4'h2;
      keys[2] = CMD_ADD;
      do_reset();
      while (ni < 3 && cyc < 200) begin
         key_valid = (np < 3);
         key_code = 4'h0;
         if (np < 3)
            key_code = keys[np];
         st = (left > 0) ? ST_PRINT : ST_READY;
         if (left > 0)
            left--;
         calc_status = st;
         tick();
         cyc++;
         if (key_valid)
            np++;
         if (calc_cmd !== CMD_IDLE) begin
            total++;
            if (calc_cmd !== keys[ni]) begin
               bad++;
               $display("FAIL seq_cmd: got %h want %h",
                        calc_cmd, keys[ni]);
            end
            total++;
            if (st !== ST_READY) begin
               bad++;
               $display("FAIL seq_ready: got st=%b want 10", st);
            end
            if (ni > 0) begin
               total++;
               if (cyc - last !== 11) begin
                  bad++;
                  $display("FAIL seq_wait: got %0d want 11",
                           cyc - last);
               end
            end
            last = cyc;
            if (calc_cmd <= 4'h9)
               left = 9;
            ni++;
         end
      end
      key_valid = 1'b0;
      calc_status = ST_READY;
      total++;
      if (ni !== 3) begin
         bad++;
         $display("FAIL seq_count: got %0d want 3", ni);
      end
      repeat (3) begin
         tick();
         total++;
         if (busy !== 1'b1) begin
            bad++;
            $display("FAIL seq_ackwin: got busy=%b want 1", busy);
         end
      end
      tick();
      total++;
      if (busy !== 1'b0) begin
         bad++;
         $display("FAIL seq_timeout: got busy=%b want 0", busy);
      end
   endtask

   task automatic test_busy_hold();
      do_reset();
      key_valid = 1'b1;
      key_code = CMD_MUL;
      tick();
      key_code = 4'h7;
      tick();
      total++;
      if (calc_cmd !== CMD_MUL) begin
         bad++;
         $display("FAIL bsy_issue: got %h want c", calc_cmd);
      end
      calc_status = ST_BUSY;
      key_code = 4'h8;
      tick();
      key_valid = 1'b0;
      for (int i = 0; i < 20; i++) begin
         total++;
         if (calc_cmd !== CMD_IDLE || fifo_level !== LW'(2)) begin
            bad++;
            $display("FAIL bsy_hold: got cmd=%h lvl=%0d want d 2",
                     calc_cmd, fifo_level);
         end
         tick();
      end
      calc_status = ST_READY;
      tick();
      total++;
      if (calc_cmd !== CMD_IDLE) begin
         bad++;
         $display("FAIL bsy_rel0: got %h want d", calc_cmd);
      end
      tick();
      total++;
      if (calc_cmd !== 4'h7 || fifo_level !== LW'(1)) begin
         bad++;
         $display("FAIL bsy_rel1: got cmd=%h lvl=%0d want 7 1",
                  calc_cmd, fifo_level);
      end
   endtask

   task automatic test_overflow();
      logic [3:0] k0;
      do_reset();
      calc_status = ST_PRINT;
      k0 = 4'h0;
      for (int i = 0; i < 9; i++) begin
         total++;
         if (key_ready !== (i < 8) || overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_fill%0d: got rdy=%b ovf=%b want %b 0",
                     i, key_ready, overflow, (i < 8));
         end
         key_valid = 1'b1;
         key_code = 4'($urandom_range(0, 9));
         if (i == 0)
            k0 = key_code;
         tick();
      end
      total++;
      if (overflow !== 1'b1 || fifo_level !== LW'(8)) begin
         bad++;
         $display("FAIL ovf_set: got ovf=%b lvl=%0d want 1 8",
                  overflow, fifo_level);
      end
      calc_status = ST_READY;
      tick();
      key_valid = 1'b0;
      total++;
      if (calc_cmd !== k0 || fifo_level !== LW'(7)) begin
         bad++;
         $display("FAIL ovf_fullpop: got cmd=%h lvl=%0d want %h 7",
                  calc_cmd, fifo_level, k0);
      end
   endtask

   task automatic test_push_pop();
      logic [3:0] k0;
      do_reset();
      calc_status = ST_PRINT;
      key_valid = 1'b1;
      k0 = rand_key();
      for (int i = 0; i < 4; i++) begin
         key_code = (i == 0) ? k0 : rand_key();
         tick();
      end
      key_code = rand_key();
      calc_status = ST_READY;
      tick();
      key_valid = 1'b0;
      calc_status = ST_PRINT;
      total++;
      if (calc_cmd !== k0 || fifo_level !== LW'(4)) begin
         bad++;
         $display("FAIL pp_same: got cmd=%h lvl=%0d want %h 4",
                  calc_cmd, fifo_level, k0);
      end
      tick();
      total++;
      if (fifo_level !== LW'(4)) begin
         bad++;
         $display("FAIL pp_after: got %0d want 4", fifo_level);
      end
   endtask

   task automatic test_error();
      do_reset();
      calc_status = ST_PRINT;
      key_valid = 1'b1;
      repeat (3) begin
         key_code = rand_key();
         tick();
      end
      key_valid = 1'b0;
      calc_status = ST_ERR;
      tick();
      total++;
      if (error !== 1'b1 || fifo_level !== LW'(0)) begin
         bad++;
         $display("FAIL err_set: got err=%b lvl=%0d want 1 0",
                  error, fifo_level);
      end
      total++;
      if (key_ready !== 1'b0 || calc_cmd !== CMD_IDLE) begin
         bad++;
         $display("FAIL err_out: got rdy=%b cmd=%h want 0 d",
                  key_ready, calc_cmd);
      end
      calc_status = ST_READY;
      key_valid = 1'b1;
      repeat (4) begin
         key_code = rand_key();
         tick();
         total++;
         if ({error, overflow} !== 2'b10 ||
             fifo_level !== LW'(0) || calc_cmd !== CMD_IDLE) begin
            bad++;
            $display("FAIL err_stick: got e=%b o=%b l=%0d c=%h want 1 0 0 d",
                     error, overflow, fifo_level, calc_cmd);
         end
      end
      key_valid = 1'b0;
      reset = 1'b1;
      #2;
      total++;
      if (error !== 1'b0 || key_ready !== 1'b1) begin
         bad++;
         $display("FAIL err_reset: got err=%b rdy=%b want 0 1",
                  error, key_ready);
      end
      tick();
      reset = 1'b0;
   endtask

   task automatic test_wrap();
      int n = 0;
      int cyc = 0;
      do_reset();
      while (n < 256 && cyc < 3000) begin
         key_valid = (fifo_level < LW'(6));
         key_code = rand_key();
         tick();
         cyc++;
         if (calc_cmd !== CMD_IDLE) begin
            n++;
            total++;
            if (issued_count !== CNT_W'(n)) begin
               bad++;
               $display("FAIL wrap_cnt: got %0d want %0d",
                        issued_count, n % 256);
            end
         end
      end
      key_valid = 1'b0;
      total++;
      if (n !== 256 || issued_count !== CNT_W'(0)) begin
         bad++;
         $display("FAIL wrap_zero: got n=%0d cnt=%0d want 256 0",
                  n, issued_count);
      end
   endtask

   task automatic test_random();
      logic [3:0] exp_q[$];
      logic [1:0] st;
      logic [1:0] hold_st;
      int n = 40;
      int np = 0;
      int ni = 0;
      int lvl = 0;
      int left = 0;
      int cyc = 0;
      int last = -100;
      hold_st = ST_READY;
      do_reset();
      while (ni < n && cyc < 4000) begin
         key_valid = (np < n) && (lvl < DEPTH) &&
                     ($urandom_range(0, 2) != 0);
         key_code = rand_key();
         st = (left > 0) ? hold_st : ST_READY;
         if (left > 0)
            left--;
         calc_status = st;
         tick();
         cyc++;
         if (key_valid) begin
            exp_q.push_back(key_code);
            np++;
            lvl++;
         end
         if (calc_cmd !== CMD_IDLE) begin
            total++;
            if (exp_q.size() == 0 || calc_cmd !== exp_q[0]) begin
               bad++;
               $display("FAIL rnd_cmd: got %h want %h", calc_cmd,
                        (exp_q.size() != 0) ? exp_q[0] : CMD_IDLE);
            end
            if (exp_q.size() != 0)
               void'(exp_q.pop_front());
            total++;
            if (st !== ST_READY || cyc - last < 3) begin
               bad++;
               $display("FAIL rnd_pace: got st=%b gap=%0d want 10 >=3",
                        st, cyc - last);
            end
            last = cyc;
            lvl--;
            ni++;
            if (calc_cmd <= 4'h9) begin
               hold_st = ST_PRINT;
               left = $urandom_range(1, 10);
            end else if (calc_cmd == CMD_EQ) begin
               hold_st = ST_BUSY;
               left = $urandom_range(1, 10);
            end
         end
         total++;
         if (fifo_level !== LW'(lvl) || key_ready !== (lvl < DEPTH)) begin
            bad++;
            $display("FAIL rnd_level: got %0d rdy=%b want %0d",
                     fifo_level, key_ready, lvl);
         end
      end
      key_valid = 1'b0;
      calc_status = ST_READY;
      total++;
      if (ni !== n || issued_count !== CNT_W'(n)) begin
         bad++;
         $display("FAIL rnd_done: got n=%0d cnt=%0d want %0d",
                  ni, issued_count, n);
      end
      total++;
      if ({error, overflow} !== 2'b00) begin
         bad++;
         $display("FAIL rnd_flags: got %b want 00", {error, overflow});
      end
   endtask

   initial begin
      reset = 1'b1;
      key_valid = 1'b0;
      key_code = 4'h0;
      calc_status = ST_READY;
      test_reset();
      test_latency();
      test_sequence();
      test_busy_hold();
      test_overflow();
      test_push_pop();
      test_error();
      test_wrap();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
